// File: rtl/arbiter_4_entries.sv
// Round-robin arbiter for a shared 4-entry mux path. Each grant lasts at most
// MAX_HOLD cycles. Every release is followed by one IDLE turnaround cycle.
module arbiter_4_entries #(
    parameter int unsigned MAX_HOLD = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [3:0] req,
    output logic [3:0] grant,
    output logic       s0,
    output logic       s1,
    output logic       busy,
    output logic [3:0] hold_cnt,
    output logic       dbg_state_o,
    output logic [1:0] dbg_ptr_o
);

    // Protocol: a requester holds req[i] high for as long as it wants the path.
    // It owns the path on every cycle that grant[i] is high. Dropping req[i]
    // releases the path on the next edge.
    typedef enum logic {
        IDLE  = 1'b0,
        GRANT = 1'b1
    } state_t;

    localparam logic [3:0] MAX_HOLD_C = 4'(MAX_HOLD);

    state_t     state_q, state_d;
    logic [1:0] ptr_q, ptr_d;
    logic [1:0] owner_q, owner_d;
    logic [3:0] grant_q, grant_d;
    logic [3:0] hold_q, hold_d;
    logic [1:0] pick_idx;
    logic [1:0] cand_idx;

    // Scan from the highest offset down, so the lowest offset from ptr wins.
    always_comb begin
        pick_idx = ptr_q;
        cand_idx = ptr_q;
        for (int k = 3; k >= 0; k--) begin
            cand_idx = ptr_q + 2'(k);
            if (req[cand_idx]) pick_idx = cand_idx;
        end
    end

    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        owner_d = owner_q;
        grant_d = grant_q;
        hold_d  = hold_q;
        unique case (state_q)
            IDLE: begin
                if (req != 4'b0000) begin
                    state_d = GRANT;
                    owner_d = pick_idx;
                    grant_d = 4'b0001 << pick_idx;
                    hold_d  = 4'd1;
                end
            end
            GRANT: begin
                if (req[owner_q] && (hold_q < MAX_HOLD_C)) begin
                    hold_d = hold_q + 4'd1;
                end else begin
                    // owner_q is kept so the mux select stays stable while idle.
                    state_d = IDLE;
                    grant_d = 4'b0000;
                    hold_d  = 4'd0;
                    ptr_d   = owner_q + 2'd1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            ptr_q   <= 2'd0;
            owner_q <= 2'd0;
            grant_q <= 4'b0000;
            hold_q  <= 4'd0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            owner_q <= owner_d;
            grant_q <= grant_d;
            hold_q  <= hold_d;
        end
    end

    assign grant       = grant_q;
    assign s0          = owner_q[0];
    assign s1          = owner_q[1];
    assign busy        = (state_q == GRANT);
    assign hold_cnt    = hold_q;
    assign dbg_state_o = state_q;
    assign dbg_ptr_o   = ptr_q;

endmodule

// File: tb/tb_arbiter_4_entries.sv
// Directed bench for arbiter_4_entries (MAX_HOLD = 4) with hand-computed expectations.
module tb_arbiter_4_entries;

    logic       clk;
    logic       rst;
    logic [3:0] req;
    logic [3:0] grant;
    logic       s0;
    logic       s1;
    logic       busy;
    logic [3:0] hold_cnt;
    logic       dbg_state;
    logic [1:0] dbg_ptr;

    int n_cmp = 0;
    int n_err = 0;

    arbiter_4_entries #(.MAX_HOLD(4)) dut (
        .clk(clk),
        .rst(rst),
        .req(req),
        .grant(grant),
        .s0(s0),
        .s1(s1),
        .busy(busy),
        .hold_cnt(hold_cnt),
        .dbg_state_o(dbg_state),
        .dbg_ptr_o(dbg_ptr)
    );

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic expect_out(input string tag, input logic [3:0] g, input logic [1:0] sel,
                              input logic b, input logic [3:0] h);
        check({tag, ".grant"}, {4'b0, grant}, {4'b0, g});
        check({tag, ".sel"}, {6'b0, s1, s0}, {6'b0, sel});
        check({tag, ".busy"}, {7'b0, busy}, {7'b0, b});
        check({tag, ".hold"}, {4'b0, hold_cnt}, {4'b0, h});
    endtask

    task automatic check_ptr(input string tag, input logic [1:0] p);
        check({tag, ".ptr"}, {6'b0, dbg_ptr}, {6'b0, p});
    endtask

    // Advance one edge and land 1 time unit after it.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst = 1'b1;
        req = 4'b0000;
        step();
        step();
        expect_out("reset", 4'b0000, 2'd0, 1'b0, 4'd0);
        check_ptr("reset", 2'd0);
        check("reset.state", {7'b0, dbg_state}, 8'd0);
        rst = 1'b0;

        // Single request: requester 2 is granted one edge later.
        req = 4'b0100;
        step();
        expect_out("single", 4'b0100, 2'd2, 1'b1, 4'd1);
        req = 4'b0000;
        step();
        expect_out("single_rel", 4'b0000, 2'd2, 1'b0, 4'd0);
        check_ptr("single_rel", 2'd3);
        step();
        expect_out("idle_hold", 4'b0000, 2'd2, 1'b0, 4'd0);

        // Hold limit: ptr = 3, the search wraps to requester 0.
        req = 4'b0001;
        for (int h = 1; h <= 4; h++) begin
            step();
            expect_out($sformatf("hold%0d", h), 4'b0001, 2'd0, 1'b1, 4'(h));
        end
        step();
        expect_out("hold_rel", 4'b0000, 2'd0, 1'b0, 4'd0);
        check_ptr("hold_rel", 2'd1);
        step();
        expect_out("hold_regrant", 4'b0001, 2'd0, 1'b1, 4'd1);
        req = 4'b0000;
        step();
        expect_out("hold_rel2", 4'b0000, 2'd0, 1'b0, 4'd0);

        // Round robin from a fresh reset: owners 0,1,2,3,0, each held 4 cycles.
        rst = 1'b1;
        #2;
        rst = 1'b0;
        check_ptr("rr_reset", 2'd0);
        req = 4'b1111;
        for (int o = 0; o < 5; o++) begin
            for (int h = 1; h <= 4; h++) begin
                step();
                expect_out($sformatf("rr_o%0d_h%0d", o, h), 4'b0001 << (o % 4), 2'(o % 4), 1'b1, 4'(h));
            end
            step();
            expect_out($sformatf("rr_idle%0d", o), 4'b0000, 2'(o % 4), 1'b0, 4'd0);
        end
        req = 4'b0000;
        check_ptr("rr_end", 2'd1);

        // Early release: owner 1 drops its request at hold_cnt = 2.
        req = 4'b0010;
        step();
        expect_out("early_g1", 4'b0010, 2'd1, 1'b1, 4'd1);
        step();
        expect_out("early_g2", 4'b0010, 2'd1, 1'b1, 4'd2);
        req = 4'b0000;
        step();
        expect_out("early_rel", 4'b0000, 2'd1, 1'b0, 4'd0);
        check_ptr("early_rel", 2'd2);

        // Async reset mid-grant, between edges.
        req = 4'b0100;
        step();
        expect_out("ar_grant", 4'b0100, 2'd2, 1'b1, 4'd1);
        #3;
        rst = 1'b1;
        #1;
        expect_out("ar_async", 4'b0000, 2'd0, 1'b0, 4'd0);
        check_ptr("ar_async", 2'd0);
        req = 4'b1010;
        #3;
        rst = 1'b0;
        step();
        expect_out("ar_after", 4'b0010, 2'd1, 1'b1, 4'd1);
        req = 4'b0000;
        step();
        expect_out("ar_rel", 4'b0000, 2'd1, 1'b0, 4'd0);
        check_ptr("ar_rel", 2'd2);

        // Non-owner noise: owner 2 while req[0]/req[3] toggle.
        req = 4'b0100;
        for (int h = 1; h <= 4; h++) begin
            step();
            expect_out($sformatf("noise_h%0d", h), 4'b0100, 2'd2, 1'b1, 4'(h));
            req = {h[0], 1'b1, 1'b0, ~h[0]};
        end
        req = 4'b0000;
        step();
        expect_out("noise_rel", 4'b0000, 2'd2, 1'b0, 4'd0);
        check_ptr("noise_rel", 2'd3);

        // Noise with owner 2 dropping req[2] early; ptr=3 so pick 2 needs only req[2].
        req = 4'b0100;
        step();
        expect_out("noise2_g", 4'b0100, 2'd2, 1'b1, 4'd1);
        req = 4'b1001;
        step();
        expect_out("noise2_rel", 4'b0000, 2'd2, 1'b0, 4'd0);
        check_ptr("noise2_rel", 2'd3);
        step();
        expect_out("noise2_next", 4'b1000, 2'd3, 1'b1, 4'd1);
        req = 4'b0000;
        step();
        check_ptr("wrap", 2'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/arbiter_4_entries.md
ARBITER_4_ENTRIES -- requirements
Module: arbiter_4_entries

Interface
REQ-001 Parameter: MAX_HOLD, default 4, maximum consecutive cycles one requester SHALL hold a grant; legal range 1..15.
REQ-002 Port: clk  input  1  single clock; all state SHALL update on its rising edge.
REQ-003 Port: rst  input  1  asynchronous, active-high reset.
REQ-004 Port: req  input  4  request vector; req[i] high means requester i wants the shared 4-entry mux path.
REQ-005 Port: grant  output  4  one-hot grant; grant[i] high means requester i owns the path.
REQ-006 Port: s0  output  1  mux select bit 0, equal to bit 0 of the owner index.
REQ-007 Port: s1  output  1  mux select bit 1, equal to bit 1 of the owner index.
REQ-008 Port: busy  output  1  high while any grant is active.
REQ-009 Port: hold_cnt  output  4  number of cycles the current owner has held the grant, 0 when idle.

Function
REQ-010 The block SHALL implement two states: IDLE (no grant) and GRANT (exactly one grant bit high).
REQ-011 All outputs SHALL be registered, with no combinational path from req to any output.
REQ-012 A 2-bit priority pointer SHALL name the requester searched first; the search order is ptr, ptr+1, ptr+2, ptr+3, modulo 4.
REQ-013 In IDLE, on a rising edge with req != 0:
- the first requesting index in pointer order becomes the owner;
- the state moves to GRANT;
- grant becomes one-hot of the owner;
- {s1,s0} becomes the owner index;
- busy goes to 1 and hold_cnt to 1.
REQ-014 In IDLE, on a rising edge with req == 0, all outputs SHALL hold their values.
REQ-015 Grant latency SHALL be exactly one edge: a request sampled at edge N is granted in the output registers after edge N.
REQ-016 In GRANT, on a rising edge with req[owner] = 1 and hold_cnt < MAX_HOLD, the state SHALL stay GRANT and hold_cnt SHALL increment by 1.
REQ-017 In GRANT, on a rising edge with req[owner] = 0 or hold_cnt == MAX_HOLD, the block SHALL release:
- state goes to IDLE;
- grant becomes 4'b0000, busy 0, hold_cnt 0;
- ptr becomes (owner+1) mod 4.
REQ-018 After every release the block SHALL spend at least one cycle in IDLE (turnaround) before any new grant, even if requests are pending.
REQ-019 While in IDLE, {s1,s0} SHALL keep the index of the last owner, so the mux output stays stable.
REQ-020 Changes on non-owner req bits during GRANT SHALL have no effect on any output.
REQ-021 Pointer arithmetic SHALL wrap from 3 to 0, so owner 3 releases to ptr = 0.
REQ-022 hold_cnt SHALL never exceed MAX_HOLD.

Reset
REQ-023 While rst is high, independent of clk:
- state = IDLE;
- grant = 4'b0000, s0 = 0, s1 = 0, busy = 0, hold_cnt = 0;
- ptr = 0.
REQ-024 Reset asserted mid-grant SHALL clear the grant immediately, without waiting for an edge.
REQ-025 After rst deasserts, the first arbitration SHALL start from requester 0 priority.

Verification
REQ-026 Single request: reset, then req=4'b0100 held -> after one edge grant=4'b0100, {s1,s0}=2'b10, busy=1, hold_cnt=1.
REQ-027 Hold limit (MAX_HOLD=4): req=4'b0001 held continuously -> grant stays 4 cycles (hold_cnt 1,2,3,4), then 1 IDLE cycle, then requester 0 is re-granted.
REQ-028 Round robin: req=4'b1111 held -> owners in order 0,1,2,3,0, each separated by one IDLE cycle.
REQ-029 Early release: owner 1 drops req[1] at hold_cnt=2 -> next edge grant=0, busy=0, {s1,s0} stays 2'b01, ptr=2.
REQ-030 Async reset: assert rst mid-grant, between edges -> grant=0 and busy=0 immediately; after release with req=4'b1010 -> requester 1 is granted.
REQ-031 Non-owner noise: owner 2 active while req[0], req[3] toggle every cycle -> grant stays 4'b0100 until the hold limit is reached or req[2] drops.
